axi_mem_slave: RTL and testbench

AXI4 memory-mapped slave with an internal word-array memory; the responder at the far end of the cache's `M_AXI_*` master port. It accepts single and burst writes (AW/W/B) and reads (AR/R) with one outstanding transaction per direction. The read and write paths are independent. It serves as the backing-memory model for cache simulation and as a synthesizable scratch RAM.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_mem_slave_if.sv | 63 ++++++
 rtl/axi_mem_ram.sv | 36 +++
 rtl/axi_mem_slave.sv | 216 +++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and burst index helpers for axi_mem_slave.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_8B = 3'd3;

   localparam int unsigned IDX_MAX_W = 32;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // FIXED holds the word; INCR, WRAP and reserved all step by one word
   function automatic logic [IDX_MAX_W-1:0] next_idx(input logic [IDX_MAX_W-1:0] idx,
                                                     input logic [1:0]           burst);
      return (burst == BURST_FIXED) ? idx : idx + IDX_MAX_W'(1);
   endfunction

   // Response codes are ordered so the numerically larger one wins
   function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [1:0] start_resp(input logic [1:0] burst, input logic [2:0] size);
      return ((burst == BURST_FIXED || burst == BURST_INCR) && size == SIZE_8B) ? RESP_OKAY
                                                                               : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 slave-side bus bundle connecting a master to axi_mem_slave.
interface axi_mem_slave_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 4
);
   logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID;
   logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [7:0]                  S_AXI_AWLEN;
   logic [2:0]                  S_AXI_AWSIZE;
   logic [1:0]                  S_AXI_AWBURST;
   logic                        S_AXI_AWVALID;
   logic                        S_AXI_AWREADY;
   logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                        S_AXI_WLAST;
   logic                        S_AXI_WVALID;
   logic                        S_AXI_WREADY;
   logic [AXI_ID_WIDTH-1:0]     S_AXI_BID;
   logic [1:0]                  S_AXI_BRESP;
   logic                        S_AXI_BVALID;
   logic                        S_AXI_BREADY;
   logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID;
   logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [7:0]                  S_AXI_ARLEN;
   logic [2:0]                  S_AXI_ARSIZE;
   logic [1:0]                  S_AXI_ARBURST;
   logic                        S_AXI_ARVALID;
   logic                        S_AXI_ARREADY;
   logic [AXI_ID_WIDTH-1:0]     S_AXI_RID;
   logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                  S_AXI_RRESP;
   logic                        S_AXI_RLAST;
   logic                        S_AXI_RVALID;
   logic                        S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      output S_AXI_RREADY
   );

endinterface

// File: rtl/axi_mem_ram.sv
// Word RAM with byte-enabled write port and registered read port; a read and write
// to the same word on one edge returns the old contents. Contents survive reset.
module axi_mem_ram #(
   parameter  int unsigned DEPTH  = 1024,
   parameter  int unsigned DATA_W = 64,
   localparam int unsigned IDX_W  = $clog2(DEPTH),
   localparam int unsigned STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  widx_i,
   input  logic [STRB_W-1:0] wstrb_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic              rzero_i,
   input  logic [IDX_W-1:0]  ridx_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (rst_n && we_i && wstrb_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[ridx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) FSMs over one RAM.
// Define AXI_SLV_RANGE_CHECK_EN to answer out-of-range bursts with DECERR.
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned MEM_DEPTH      = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   axi_mem_slave_if.slave   s_axi
);
   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
   localparam int unsigned ID_W  = AXI_ID_WIDTH;
   localparam int unsigned A_W   = AXI_ADDR_WIDTH;

   w_state_t          w_state_q, w_state_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [IDX_W-1:0]  widx_q, widx_d;
   logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic [1:0]        wburst_q, wburst_d, bresp_q, bresp_d;
   logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

   r_state_t          r_state_q, r_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [IDX_W-1:0]  ridx_q, ridx_d;
   logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
   logic              rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;

   logic              ram_we_c, ram_re_c, ram_rzero_c;
   logic [IDX_W-1:0]  ram_ridx_c;
   logic [AXI_DATA_WIDTH-1:0] ram_rdata;

   logic aw_hi_c, ar_hi_c, aw_oor_c, ar_oor_c, unused_c;

   assign aw_hi_c = |s_axi.S_AXI_AWADDR[A_W-1:IDX_W+3];
   assign ar_hi_c = |s_axi.S_AXI_ARADDR[A_W-1:IDX_W+3];
`ifdef AXI_SLV_RANGE_CHECK_EN
   assign aw_oor_c = aw_hi_c;
   assign ar_oor_c = ar_hi_c;
`else
   assign aw_oor_c = 1'b0;
   assign ar_oor_c = 1'b0;
`endif
   // Byte-offset bits never select anything; high bits only matter with range checking
   assign unused_c = ^{s_axi.S_AXI_AWADDR[2:0], s_axi.S_AXI_ARADDR[2:0], aw_hi_c, ar_hi_c};

   // Write path next-state
   always_comb begin
      w_state_d = w_state_q;
      wid_d     = wid_q;
      widx_d    = widx_q;
      wlen_d    = wlen_q;
      wburst_d  = wburst_q;
      wcnt_d    = wcnt_q;
      bresp_d   = bresp_q;
      ram_we_c  = 1'b0;
      case (w_state_q)
         W_IDLE: if (s_axi.S_AXI_AWVALID) begin
            wid_d     = s_axi.S_AXI_AWID;
            widx_d    = s_axi.S_AXI_AWADDR[3 +: IDX_W];
            wlen_d    = s_axi.S_AXI_AWLEN;
            wburst_d  = s_axi.S_AXI_AWBURST;
            wcnt_d    = 8'd0;
            bresp_d   = aw_oor_c ? RESP_DECERR
                                 : start_resp(s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWSIZE);
            w_state_d = W_DATA;
         end
         W_DATA: if (s_axi.S_AXI_WVALID) begin
            ram_we_c = (bresp_q != RESP_DECERR);
            // Either WLAST or the beat count ends the burst; disagreement flags SLVERR
            if (s_axi.S_AXI_WLAST || wcnt_q == wlen_q) begin
               if (s_axi.S_AXI_WLAST != (wcnt_q == wlen_q)) bresp_d = worse_resp(bresp_q, RESP_SLVERR);
               w_state_d = W_RESP;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
               widx_d = IDX_W'(next_idx(IDX_MAX_W'(widx_q), wburst_q));
            end
         end
         W_RESP: if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         wid_q     <= '0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wburst_q  <= '0;
         wcnt_q    <= '0;
         bresp_q   <= RESP_OKAY;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         wid_q     <= wid_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wburst_q  <= wburst_d;
         wcnt_q    <= wcnt_d;
         bresp_q   <= bresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
      end
   end

   // Read path next-state; the RAM is loaded with the beat that will be presented next
   always_comb begin
      r_state_d   = r_state_q;
      rid_d       = rid_q;
      ridx_d      = ridx_q;
      rlen_d      = rlen_q;
      rburst_d    = rburst_q;
      rcnt_d      = rcnt_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      ram_re_c    = 1'b0;
      ram_ridx_c  = IDX_W'(next_idx(IDX_MAX_W'(ridx_q), rburst_q));
      ram_rzero_c = (rresp_q == RESP_DECERR);
      case (r_state_q)
         R_IDLE: if (s_axi.S_AXI_ARVALID) begin
            rid_d       = s_axi.S_AXI_ARID;
            ridx_d      = s_axi.S_AXI_ARADDR[3 +: IDX_W];
            rlen_d      = s_axi.S_AXI_ARLEN;
            rburst_d    = s_axi.S_AXI_ARBURST;
            rcnt_d      = 8'd0;
            rresp_d     = ar_oor_c ? RESP_DECERR
                                   : start_resp(s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARSIZE);
            rlast_d     = (s_axi.S_AXI_ARLEN == 8'd0);
            ram_re_c    = 1'b1;
            ram_ridx_c  = s_axi.S_AXI_ARADDR[3 +: IDX_W];
            ram_rzero_c = ar_oor_c;
            r_state_d   = R_DATA;
         end
         R_DATA: if (s_axi.S_AXI_RREADY) begin
            if (rlast_q) begin
               rlast_d   = 1'b0;
               r_state_d = R_IDLE;
            end else begin
               rcnt_d   = rcnt_q + 8'd1;
               ridx_d   = ram_ridx_c;
               ram_re_c = 1'b1;
               rlast_d  = (rcnt_d == rlen_q);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rburst_q  <= '0;
         rcnt_q    <= '0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rburst_q  <= rburst_d;
         rcnt_q    <= rcnt_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   axi_mem_ram #(
      .DEPTH  (MEM_DEPTH),
      .DATA_W (AXI_DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (ram_we_c),
      .widx_i  (widx_q),
      .wstrb_i (s_axi.S_AXI_WSTRB),
      .wdata_i (s_axi.S_AXI_WDATA),
      .re_i    (ram_re_c),
      .rzero_i (ram_rzero_c),
      .ridx_i  (ram_ridx_c),
      .rdata_o (ram_rdata)
   );

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BID     = wid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RID     = rid_q;
   assign s_axi.S_AXI_RDATA   = ram_rdata;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RLAST   = rlast_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: a word-array reference model predicts every B and R beat.
module tb_axi_mem_slave;
   localparam int unsigned MEM_DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_mem_slave_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) bus ();

   axi_mem_slave #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_axi (bus)
   );

   typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;

   b_exp_t b_q[$];
   r_exp_t r_q[$];

   int vectors = 0;
   int miscompares = 0;
   int rdy_mode = 0;

   logic [63:0] mdl [MEM_DEPTH];
   logic [63:0] wdat [256];
   logic [7:0]  wstb [256];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [1:0] burst,
                                           input logic [2:0] size);
      logic [1:0] r;
      r = (burst > 2'd1 || size != 3'd3) ? 2'b10 : 2'b00;
`ifdef AXI_SLV_RANGE_CHECK_EN
      if (addr >= 32'(MEM_DEPTH * 8)) r = 2'b11;
`else
      if (addr[0] === 1'bx) r = 2'b11;
`endif
      return r;
   endfunction

   // Ready generator for B and R: 0 always, 1 alternate, 2 random, 3 RREADY held low
   initial begin
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: begin bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1; end
            1: begin bus.S_AXI_BREADY = ~bus.S_AXI_BREADY; bus.S_AXI_RREADY = ~bus.S_AXI_RREADY; end
            2: begin bus.S_AXI_BREADY = 1'($urandom); bus.S_AXI_RREADY = 1'($urandom); end
            default: begin bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b0; end
         endcase
      end
   end

   // Monitors: pop and compare on every completed handshake
   always @(negedge clk) begin
      if (rst_n && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
         if (b_q.size() == 0) fail_now("b_unexpected");
         else begin
            b_exp_t e;
            e = b_q.pop_front();
            chk("bresp", 64'(bus.S_AXI_BRESP), 64'(e.resp));
            chk("bid", 64'(bus.S_AXI_BID), 64'(e.id));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
         if (r_q.size() == 0) fail_now("r_unexpected");
         else begin
            r_exp_t e;
            e = r_q.pop_front();
            chk("rdata", bus.S_AXI_RDATA, e.data);
            chk("rresp", 64'(bus.S_AXI_RRESP), 64'(e.resp));
            chk("rlast", 64'(bus.S_AXI_RLAST), 64'(e.last));
            chk("rid", 64'(bus.S_AXI_RID), 64'(e.id));
         end
      end
   end

   // sel: 0 AW, 1 W, 2 AR; returns #1 after the handshake edge
   task automatic wait_hs(input int sel, input string nm);
      int t;
      logic r;
      t = 0;
      forever begin
         @(negedge clk);
         r = (sel == 0) ? bus.S_AXI_AWREADY : (sel == 1) ? bus.S_AXI_WREADY : bus.S_AXI_ARREADY;
         if (r) break;
         t++;
         if (t > 200) begin fail_now(nm); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int sel, input int limit, input string nm);
      int t;
      t = 0;
      while (((sel == 0) ? b_q.size() : r_q.size()) != 0) begin
         @(posedge clk);
         t++;
         if (t > limit) begin
            fail_now(nm);
            if (sel == 0) b_q.delete(); else r_q.delete();
            break;
         end
      end
      #1;
   endtask

   // Write burst using wdat/wstb; WLAST is driven on beat wlb
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int wlb);
      int idx, n;
      logic [1:0] resp;
      resp = exp_resp(addr, burst, size);
      if (wlb != int'(len) && resp != 2'b11) resp = 2'b10;
      n = (wlb < int'(len)) ? wlb + 1 : int'(len) + 1;
      idx = int'((addr >> 3) % MEM_DEPTH);
      for (int b = 0; b < n; b++) begin
         if (resp != 2'b11)
            for (int k = 0; k < 8; k++)
               if (wstb[b][k]) mdl[idx][8*k +: 8] = wdat[b][8*k +: 8];
         if (burst != 2'b00) idx = (idx + 1) % MEM_DEPTH;
      end
      b_q.push_back('{id: id, resp: resp});

      bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len;
      bus.S_AXI_AWSIZE = size; bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
      wait_hs(0, "aw_timeout");
      bus.S_AXI_AWVALID = 1'b0;
      for (int b = 0; b < n; b++) begin
         bus.S_AXI_WDATA = wdat[b]; bus.S_AXI_WSTRB = wstb[b];
         bus.S_AXI_WLAST = (b == wlb); bus.S_AXI_WVALID = 1'b1;
         wait_hs(1, "w_timeout");
      end
      bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
      wait_drain(0, 300, "b_timeout");
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input bit push);
      int idx;
      logic [1:0] resp;
      resp = exp_resp(addr, burst, size);
      idx = int'((addr >> 3) % MEM_DEPTH);
      if (push)
         for (int b = 0; b <= int'(len); b++) begin
            r_q.push_back('{data: (resp == 2'b11) ? 64'd0 : mdl[idx], resp: resp,
                            last: (b == int'(len)), id: id});
            if (burst != 2'b00) idx = (idx + 1) % MEM_DEPTH;
         end
      bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len;
      bus.S_AXI_ARSIZE = size; bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
      wait_hs(2, "ar_timeout");
      bus.S_AXI_ARVALID = 1'b0;
      if (push) wait_drain(1, 2000, "r_timeout");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [7:0]  ln;
      logic [1:0]  bu;
      logic [2:0]  sz;
      int          wlb;
      bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
      bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
      bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
      chk("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
      chk("rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
      chk("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
      chk("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
      chk("rst_rlast", 64'(bus.S_AXI_RLAST), 64'd0);
      chk("rst_bresp", 64'(bus.S_AXI_BRESP), 64'd0);
      chk("rst_rresp", 64'(bus.S_AXI_RRESP), 64'd0);
      chk("rst_bid", 64'(bus.S_AXI_BID), 64'd0);
      chk("rst_rid", 64'(bus.S_AXI_RID), 64'd0);
      chk("rst_rdata", bus.S_AXI_RDATA, 64'd0);
      @(posedge clk); #1;

      // Fill the whole memory so every later read has a known model value
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 256; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
         do_write(32'(k * 2048), 8'd255, 2'b01, 3'd3, 4'(k), 255);
      end

      wdat[0] = 64'h0123456789ABCDEF; wstb[0] = 8'hFF;
      do_write(32'h0, 8'd0, 2'b01, 3'd3, 4'd5, 0);
      do_read(32'h0, 8'd0, 2'b01, 3'd3, 4'd6, 1'b1);

      for (int b = 0; b < 4; b++) begin wdat[b] = 64'(b + 1); wstb[b] = 8'hFF; end
      do_write(32'h40, 8'd3, 2'b01, 3'd3, 4'd1, 3);
      rdy_mode = 1;
      do_read(32'h40, 8'd3, 2'b01, 3'd3, 4'd2, 1'b1);
      rdy_mode = 0;

      wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
      do_write(32'h100, 8'd0, 2'b01, 3'd3, 4'd3, 0);
      wdat[0] = 64'h0; wstb[0] = 8'h0F;
      do_write(32'h100, 8'd0, 2'b01, 3'd3, 4'd3, 0);
      chk("partial_model", mdl[32], 64'hFFFF_FFFF_0000_0000);
      do_read(32'h100, 8'd0, 2'b01, 3'd3, 4'd4, 1'b1);

      for (int b = 0; b < 4; b++) begin wdat[b] = 64'hA0 + 64'(b); wstb[b] = 8'hFF; end
      do_write(32'h200, 8'd3, 2'b01, 3'd3, 4'd7, 2);
      chk("awready_after_b", 64'(bus.S_AXI_AWREADY), 64'd1);
      do_read(32'h200, 8'd3, 2'b01, 3'd3, 4'd7, 1'b1);

      for (int b = 0; b < 4; b++) begin wdat[b] = 64'hF00 + 64'(b); wstb[b] = 8'hFF; end
      do_write(32'h300, 8'd3, 2'b00, 3'd3, 4'd8, 3);
      do_read(32'h2F8, 8'd2, 2'b01, 3'd3, 4'd8, 1'b1);
      do_read(32'h1FF8, 8'd2, 2'b01, 3'd2, 4'd9, 1'b1);

      do_read(32'h8000_0000, 8'd0, 2'b01, 3'd3, 4'd10, 1'b1);

      for (int i = 0; i < 60; i++) begin
         a  = 32'($urandom_range(0, 32'h3FFF));
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000 | 32'($urandom_range(0, 255));
         ln = 8'($urandom_range(0, 7));
         bu = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b01;
         sz = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd3;
         wlb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(ln) + 1)) : int'(ln);
         rdy_mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < 9; b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'($urandom); end
            do_write(a, ln, bu, sz, 4'($urandom), wlb);
         end else begin
            do_read(a, ln, bu, sz, 4'($urandom), 1'b1);
         end
      end

      // Reset in the middle of a stalled read burst
      rdy_mode = 3;
      @(posedge clk); #1;
      do_read(32'h40, 8'd7, 2'b01, 3'd3, 4'd11, 1'b0);
      chk("pre_rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
      chk("midrst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
      chk("midrst_rlast", 64'(bus.S_AXI_RLAST), 64'd0);
      rdy_mode = 0;
      @(posedge clk); #1;
      do_read(32'h40, 8'd3, 2'b01, 3'd3, 4'd12, 1'b1);
      do_read(32'h0, 8'd0, 2'b01, 3'd3, 4'd13, 1'b1);

      chk("b_queue_empty", 64'(b_q.size()), 64'd0);
      chk("r_queue_empty", 64'(r_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
